// File: rtl/tile_pixel_engine_pkg.sv
// Shared tile definitions: default geometry, tile ids, default animation mask
// and the bitmap address layout used by both the engine and the bitmap loader.
package tile_pkg;

   localparam int DEF_TILE_W     = 16;
   localparam int DEF_TILE_H     = 16;
   localparam int DEF_PIX_W      = 4;
   localparam int DEF_NUM_TILES  = 8;
   localparam int DEF_NUM_FRAMES = 2;
   localparam int DEF_ANIM_DIV   = 32;

   localparam int DEF_XW = $clog2(DEF_TILE_W);
   localparam int DEF_YW = $clog2(DEF_TILE_H);
   localparam int DEF_TW = $clog2(DEF_NUM_TILES);
   localparam int DEF_FW = $clog2(DEF_NUM_FRAMES);
   localparam int DEF_AW = DEF_FW + DEF_TW + DEF_YW + DEF_XW;

   localparam logic [DEF_NUM_TILES-1:0] DEF_ANIM_MASK = 8'b0000_0100;

   typedef enum logic [DEF_TW-1:0] {
      TILE_EMPTY     = 3'd0,
      TILE_BRICK     = 3'd1,
      TILE_STEEL     = 3'd2,
      TILE_WATER     = 3'd3,
      TILE_TREE      = 3'd4,
      TILE_ICE       = 3'd5,
      TILE_BASE      = 3'd6,
      TILE_BASE_DEAD = 3'd7
   } tile_id_e;

   // Bitmap layout is {frame, tile, row, column}, column in the LSBs.
   function automatic logic [DEF_AW-1:0] tile_addr(
      input logic [DEF_FW-1:0] f,
      input logic [DEF_TW-1:0] tile,
      input logic [DEF_YW-1:0] y,
      input logic [DEF_XW-1:0] x
   );
      return {f, tile, y, x};
   endfunction

endpackage

// File: rtl/tile_pixel_engine_if.sv
// Pixel request / result handshake between the renderer and the engine.
interface tile_pixel_engine_if
   import tile_pkg::*;
#(
   parameter int TILE_W    = DEF_TILE_W,
   parameter int TILE_H    = DEF_TILE_H,
   parameter int PIX_W     = DEF_PIX_W,
   parameter int NUM_TILES = DEF_NUM_TILES
) ();

   logic                         in_valid;
   logic                         in_ready;
   logic [$clog2(NUM_TILES)-1:0] in_tile;
   logic [$clog2(TILE_W)-1:0]    in_x;
   logic [$clog2(TILE_H)-1:0]    in_y;
   logic                         in_flip_h;
   logic                         in_flip_v;
   logic                         out_valid;
   logic                         out_ready;
   logic [PIX_W-1:0]             out_pix;
   logic                         out_opaque;

   modport master (
      output in_valid, in_tile, in_x, in_y, in_flip_h, in_flip_v, out_ready,
      input  in_ready, out_valid, out_pix, out_opaque
   );

   modport slave (
      input  in_valid, in_tile, in_x, in_y, in_flip_h, in_flip_v, out_ready,
      output in_ready, out_valid, out_pix, out_opaque
   );

endinterface

// File: rtl/tile_pixel_engine_anim_timer.sv
// Animation timer: divides frame_tick pulses by ANIM_DIV and steps the
// shared animation frame, wrapping modulo NUM_FRAMES.
module tile_anim_timer
   import tile_pkg::*;
#(
   parameter int NUM_FRAMES = DEF_NUM_FRAMES,
   parameter int ANIM_DIV   = DEF_ANIM_DIV,
   localparam int CW        = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1,
   localparam int FW        = $clog2(NUM_FRAMES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_tick,
   output logic [FW-1:0] anim_frame
);

   localparam logic [CW-1:0] CNT_LAST = CW'(ANIM_DIV - 1);

   logic [CW-1:0] tick_cnt;

   // Count ticks; the tick that lands on the last count advances the frame.
   // NUM_FRAMES is a power of two, so the frame wraps by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt   <= '0;
         anim_frame <= '0;
      end else if (frame_tick) begin
         if (tick_cnt == CNT_LAST) begin
            tick_cnt   <= '0;
            anim_frame <= anim_frame + FW'(1);
         end else begin
            tick_cnt <= tick_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/tile_pixel_engine.sv
// Shared tile-pixel lookup: request -> address (S1) -> bitmap read (S2).
// Two-cycle latency, one request per cycle, whole pipe stalls on out_ready.
module tile_pixel_engine
   import tile_pkg::*;
#(
   parameter int                     TILE_W     = DEF_TILE_W,
   parameter int                     TILE_H     = DEF_TILE_H,
   parameter int                     PIX_W      = DEF_PIX_W,
   parameter int                     NUM_TILES  = DEF_NUM_TILES,
   parameter int                     NUM_FRAMES = DEF_NUM_FRAMES,
   parameter int                     ANIM_DIV   = DEF_ANIM_DIV,
   parameter logic [NUM_TILES-1:0]   ANIM_MASK  = DEF_ANIM_MASK,
   localparam int                    XW    = $clog2(TILE_W),
   localparam int                    YW    = $clog2(TILE_H),
   localparam int                    FW    = $clog2(NUM_FRAMES),
   localparam int                    AW    = $clog2(NUM_FRAMES * NUM_TILES * TILE_W * TILE_H),
   localparam int                    DEPTH = NUM_FRAMES * NUM_TILES * TILE_W * TILE_H
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_tick,
   tile_pixel_engine_if.slave   bus,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [PIX_W-1:0]     wr_data,
   output logic [FW-1:0]        anim_frame
);

   logic [PIX_W-1:0] bitmap [DEPTH];

   logic          advance;
   logic          s1_valid;
   logic [AW-1:0] s1_addr;
   logic [AW-1:0] req_addr;
   logic [XW-1:0] x_eff;
   logic [YW-1:0] y_eff;
   logic [FW-1:0] f_eff;

   tile_anim_timer #(
      .NUM_FRAMES (NUM_FRAMES),
      .ANIM_DIV   (ANIM_DIV)
   ) u_anim_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .anim_frame (anim_frame)
   );

   // The whole pipe moves only when the output slot is empty or being drained.
   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = advance;

   // Mirror and frame selection; with power-of-two tiles, W-1-x is just ~x.
   always_comb begin
      x_eff    = bus.in_flip_h ? ~bus.in_x : bus.in_x;
      y_eff    = bus.in_flip_v ? ~bus.in_y : bus.in_y;
      f_eff    = ANIM_MASK[bus.in_tile] ? anim_frame : '0;
      req_addr = {f_eff, bus.in_tile, y_eff, x_eff};
   end

   // Bitmap store: written every cycle on request, independent of stalls.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         bitmap[wr_addr] <= wr_data;
      end
   end

   // S1 latches the address (frame frozen here), S2 latches the bitmap read.
   // The read sees the array before a same-edge write (read-first).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid       <= 1'b0;
         s1_addr        <= '0;
         bus.out_valid  <= 1'b0;
         bus.out_pix    <= '0;
         bus.out_opaque <= 1'b0;
      end else if (advance) begin
         s1_valid       <= bus.in_valid;
         s1_addr        <= req_addr;
         bus.out_valid  <= s1_valid;
         bus.out_pix    <= bitmap[s1_addr];
         bus.out_opaque <= (bitmap[s1_addr] != '0);
      end
   end

endmodule

// File: tb/tb_tile_pixel_engine.sv
// Bench for tile_pixel_engine: a transaction-level model (memory image,
// tick count, queue of accepted requests) checked every cycle, plus
// directed literal expectations for each scenario.
module tb_tile_pixel_engine;
   import tile_pkg::*;

   localparam logic [7:0] MASK  = 8'b0000_1000;
   localparam int         NFR   = 2;
   localparam int         DIV   = 32;
   localparam int         DEPTH = 2 * 8 * 16 * 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        wr_en = 1'b0;
   logic [11:0] wr_addr = '0;
   logic [3:0]  wr_data = '0;
   logic [0:0]  anim_frame;

   tile_pixel_engine_if bus ();

   tile_pixel_engine #(.ANIM_MASK(MASK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .bus        (bus),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .anim_frame (anim_frame)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---------------- model ----------------
   int mem_m [DEPTH];
   int ticks = 0;
   int inflight [$];
   bit m_out_v = 1'b0;
   int m_out_pix = 0;
   bit collect = 1'b0;
   int delivered [$];

   function automatic int model_addr(int tile, int x, int y, bit fh, bit fv, int tk);
      int xe, ye, f;
      xe = fh ? 15 - x : x;
      ye = fv ? 15 - y : y;
      f  = MASK[tile] ? (tk / DIV) % NFR : 0;
      return ((f * 8 + tile) * 16 + ye) * 16 + xe;
   endfunction

   // Results leave in request order; each one reads the memory image as it
   // moves into the output slot, before that edge's write lands.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight.delete();
         m_out_v   = 1'b0;
         m_out_pix = 0;
         ticks     = 0;
      end else begin
         if (!m_out_v || bus.out_ready) begin
            if (inflight.size() > 0) begin
               m_out_v   = 1'b1;
               m_out_pix = mem_m[inflight.pop_front()];
            end else begin
               m_out_v = 1'b0;
            end
            if (bus.in_valid)
               inflight.push_back(model_addr(int'(bus.in_tile), int'(bus.in_x), int'(bus.in_y),
                                             bus.in_flip_h, bus.in_flip_v, ticks));
         end
         if (wr_en) mem_m[int'(wr_addr)] = int'(wr_data);
         if (frame_tick) ticks++;
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", int'(bus.out_valid), int'(m_out_v));
         if (m_out_v) begin
            chk("out_pix", int'(bus.out_pix), m_out_pix);
            chk("out_opaque", int'(bus.out_opaque), int'(m_out_pix != 0));
         end
         chk("in_ready", int'(bus.in_ready), int'(!m_out_v || bus.out_ready));
         chk("anim_frame", int'(anim_frame), (ticks / DIV) % NFR);
         if (collect && bus.out_valid && bus.out_ready) delivered.push_back(int'(bus.out_pix));
      end
   end

   // ---------------- stimulus ----------------
   function automatic int pk(int f, int t, int y, int x);
      return int'(tile_addr(DEF_FW'(f), DEF_TW'(t), DEF_YW'(y), DEF_XW'(x)));
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(int a, int d);
      wr_en   = 1'b1;
      wr_addr = 12'(a);
      wr_data = 4'(d);
      step();
      wr_en   = 1'b0;
   endtask

   task automatic set_req(bit v, int tile, int x, int y, bit fh, bit fv);
      bus.in_valid  = v;
      bus.in_tile   = 3'(tile);
      bus.in_x      = 4'(x);
      bus.in_y      = 4'(y);
      bus.in_flip_h = fh;
      bus.in_flip_v = fv;
   endtask

   task automatic tick_n(int n);
      repeat (n) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
      end
   endtask

   // One isolated request: accepted now, invisible after 1 edge, valid after 2.
   task automatic single(string name, int tile, int x, int y, bit fh, bit fv, int exp, bit tk);
      set_req(1'b1, tile, x, y, fh, fv);
      frame_tick = tk;
      chk({name, "_accept"}, int'(bus.in_ready), 1);
      step();
      frame_tick = 1'b0;
      set_req(1'b0, 0, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk({name, "_lat1"}, int'(bus.out_valid), 0);
      @(negedge clk);
      chk({name, "_valid"}, int'(bus.out_valid), 1);
      chk({name, "_pix"}, int'(bus.out_pix), exp);
      chk({name, "_opaque"}, int'(bus.out_opaque), int'(exp != 0));
      step();
   endtask

   initial begin
      int i;
      int held;
      bit acc;
      set_req(1'b0, 0, 0, 0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      step();
      step();
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_pix", int'(bus.out_pix), 0);
      chk("rst_out_opaque", int'(bus.out_opaque), 0);
      chk("rst_anim_frame", int'(anim_frame), 0);
      rst_n = 1'b1;
      step();

      // Bitmap load.
      for (int x = 0; x < 16; x++) wr(pk(0, TILE_STEEL, 0, x), 4);
      for (int x = 0; x < 16; x++) wr(pk(0, TILE_STEEL, 7, x), (x == 0 || x == 8) ? 4 : 1);
      wr(pk(0, TILE_WATER, 0, 0), 5);
      wr(pk(1, TILE_WATER, 0, 0), 6);
      for (int x = 1; x <= 10; x++) wr(pk(0, TILE_TREE, 0, x), x);
      wr(pk(0, TILE_BRICK, 0, 0), 4);
      wr(pk(0, TILE_EMPTY, 0, 0), 0);

      // Lookup and mirroring.
      single("steel_x1y7", 2, 1, 7, 1'b0, 1'b0, 1, 1'b0);
      single("fliph_x14", 2, 14, 7, 1'b1, 1'b0, 1, 1'b0);
      single("fliph_x15", 2, 15, 7, 1'b1, 1'b0, 4, 1'b0);
      single("flipv_y15", 2, 3, 15, 1'b0, 1'b1, 4, 1'b0);
      single("rot180", 2, 7, 8, 1'b1, 1'b1, 4, 1'b0);

      // Animation: water animates, steel does not.
      tick_n(31);
      single("water_t31", 3, 0, 0, 1'b0, 1'b0, 5, 1'b0);
      tick_n(1);
      @(negedge clk);
      chk("anim_frame_t32", int'(anim_frame), 1);
      step();
      single("water_t32", 3, 0, 0, 1'b0, 1'b0, 6, 1'b0);
      single("steel_t32", 2, 1, 7, 1'b0, 1'b0, 1, 1'b0);
      tick_n(31);
      single("water_inflight", 3, 0, 0, 1'b0, 1'b0, 6, 1'b1);
      chk("anim_frame_t64", int'(anim_frame), 0);
      single("water_t64", 3, 0, 0, 1'b0, 1'b0, 5, 1'b0);
      single("steel_t64", 2, 1, 7, 1'b0, 1'b0, 1, 1'b0);

      // Read-first on a same-edge write, then the new value.
      set_req(1'b1, 1, 0, 0, 1'b0, 1'b0);
      step();
      set_req(1'b0, 0, 0, 0, 1'b0, 1'b0);
      wr_en   = 1'b1;
      wr_addr = 12'(pk(0, TILE_BRICK, 0, 0));
      wr_data = 4'd7;
      step();
      wr_en = 1'b0;
      @(negedge clk);
      chk("rdfirst_valid", int'(bus.out_valid), 1);
      chk("rdfirst_pix", int'(bus.out_pix), 4);
      step();
      single("after_write", 1, 0, 0, 1'b0, 1'b0, 7, 1'b0);
      single("empty_idx0", 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);

      // Backpressure: 10 streamed requests, output stalled in cycles 3..6.
      collect = 1'b1;
      delivered.delete();
      i = 0;
      held = 0;
      for (int c = 0; c < 40 && delivered.size() < 10; c++) begin
         set_req(i < 10, 4, i + 1, 0, 1'b0, 1'b0);
         bus.out_ready = !(c >= 3 && c <= 6);
         #1;
         acc = bus.in_valid && bus.in_ready;
         if (c >= 3 && c <= 6) begin
            chk("bp_in_ready", int'(bus.in_ready), 0);
            if (c == 3) held = int'(bus.out_pix);
            else chk("bp_hold", int'(bus.out_pix), held);
         end
         step();
         if (acc) i++;
      end
      set_req(1'b0, 0, 0, 0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      collect = 1'b0;
      chk("bp_count", delivered.size(), 10);
      for (int k = 0; k < delivered.size() && k < 10; k++) chk("bp_order", delivered[k], k + 1);
      step();
      step();

      // Reset with two requests in flight.
      tick_n(32);
      chk("anim_before_rst", int'(anim_frame), 1);
      set_req(1'b1, 2, 1, 7, 1'b0, 1'b0);
      step();
      step();
      set_req(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_anim", int'(anim_frame), 0);
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_idle", int'(bus.out_valid), 0);
      step();
      single("post_rst", 2, 1, 7, 1'b0, 1'b0, 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
